move_input_ctrl: RTL and testbench

//  Front-end input stage for the tic-tac-toe board.
//  - Debounces two raw push-buttons: NEXT moves the cursor, PLACE places a mark.
//  - Keeps the cursor cell and the player whose turn it is.
//  - Produces a one-cycle place strobe (cell, player); the downstream board

---
 rtl/ttt_pkg.sv | 10 +
 rtl/button_debounce.sv | 60 ++++++
 rtl/move_input_ctrl.sv | 63 ++++++
 tb/tb_move_input_ctrl.sv | 143 ++++++++++++++
 4 files changed

// File: rtl/ttt_pkg.sv
// ttt_pkg: shared types and helpers for the tic-tac-toe input stage
package ttt_pkg;
    localparam int NCELLS = 9;
    typedef logic [3:0] cell_idx_t;
    typedef enum logic {PLAYER_X = 1'b0, PLAYER_O = 1'b1} player_t;
    typedef enum logic [1:0] {RELEASED, PRESS_WAIT, PRESSED, RELEASE_WAIT} btn_state_t;
    function automatic cell_idx_t next_cell(input cell_idx_t c);
        return (c == cell_idx_t'(NCELLS - 1)) ? '0 : c + cell_idx_t'(1);
    endfunction
endpackage

// File: rtl/button_debounce.sv
// button_debounce: 2-flop synchronizer plus debounce FSM emitting a 1-cycle press pulse
module button_debounce
    import ttt_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = 16
) (
    input  logic ph1,
    input  logic reset,
    input  logic raw,
    output logic press
);
    localparam int CW = $clog2(DEBOUNCE_CYCLES + 1);
    localparam logic [CW-1:0] CMAX = CW'(DEBOUNCE_CYCLES);
    logic [1:0] sync_q;
    logic [CW-1:0] cnt_q;
    btn_state_t state_q;
    logic press_q;
    logic s;
    logic done;
    assign s = sync_q[1];
    assign done = cnt_q == CMAX;
    assign press = press_q;
    // Reset lands in PRESSED so a button held through reset must be released first.
    always_ff @(posedge ph1) begin
        if (!reset) begin
            sync_q  <= '0;
            state_q <= PRESSED;
            cnt_q   <= '0;
            press_q <= 1'b0;
        end else begin
            sync_q  <= {sync_q[0], raw};
            press_q <= 1'b0;
            case (state_q)
                RELEASED: if (s) begin
                    state_q <= PRESS_WAIT;
                    cnt_q   <= CW'(1);
                end
                PRESS_WAIT: if (!s) begin
                    state_q <= RELEASED;
                    cnt_q   <= '0;
                end else if (done) begin
                    state_q <= PRESSED;
                    cnt_q   <= '0;
                    press_q <= 1'b1;
                end else cnt_q <= cnt_q + CW'(1);
                PRESSED: if (!s) begin
                    state_q <= RELEASE_WAIT;
                    cnt_q   <= CW'(1);
                end
                RELEASE_WAIT: if (s) begin
                    state_q <= PRESSED;
                    cnt_q   <= '0;
                end else if (done) begin
                    state_q <= RELEASED;
                    cnt_q   <= '0;
                end else cnt_q <= cnt_q + CW'(1);
            endcase
        end
    end
endmodule

// File: rtl/move_input_ctrl.sv
// move_input_ctrl: debounced NEXT/PLACE handling, cursor and turn tracking, place/invalid strobes
module move_input_ctrl
    import ttt_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = 16
) (
    input  logic       ph1,
    input  logic       reset,
    input  logic       btn_next,
    input  logic       btn_place,
    input  logic [8:0] occupied,
    input  logic       game_over,
    output logic [3:0] cursor,
    output logic       place_en,
    output logic [3:0] place_cell,
    output logic       player,
    output logic       invalid
);
    logic next_ev;
    logic place_ev;
    logic legal;
    logic [15:0] occ_ext;
    cell_idx_t cursor_q, cursor_d, place_cell_q, place_cell_d;
    player_t player_q, player_d;
    logic place_en_q, place_en_d, invalid_q, invalid_d;
    button_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_next (
        .ph1(ph1), .reset(reset), .raw(btn_next), .press(next_ev)
    );
    button_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_place (
        .ph1(ph1), .reset(reset), .raw(btn_place), .press(place_ev)
    );
    assign occ_ext = {7'b0, occupied};
    // PLACE wins over a simultaneous NEXT, which is simply dropped.
    always_comb begin
        legal        = !occ_ext[cursor_q] && !game_over;
        place_en_d   = place_ev && legal;
        invalid_d    = place_ev && !legal;
        place_cell_d = place_en_d ? cursor_q : place_cell_q;
        player_d     = place_en_d ? player_t'(~player_q) : player_q;
        cursor_d     = (next_ev && !place_ev) ? next_cell(cursor_q) : cursor_q;
    end
    always_ff @(posedge ph1) begin
        if (!reset) begin
            cursor_q     <= '0;
            place_cell_q <= '0;
            player_q     <= PLAYER_X;
            place_en_q   <= 1'b0;
            invalid_q    <= 1'b0;
        end else begin
            cursor_q     <= cursor_d;
            place_cell_q <= place_cell_d;
            player_q     <= player_d;
            place_en_q   <= place_en_d;
            invalid_q    <= invalid_d;
        end
    end
    assign cursor     = cursor_q;
    assign place_cell = place_cell_q;
    assign player     = player_q;
    assign place_en   = place_en_q;
    assign invalid    = invalid_q;
    a_cursor_range: assert property (@(posedge ph1) cursor_q < cell_idx_t'(NCELLS));
endmodule

// File: tb/tb_move_input_ctrl.sv
// tb_move_input_ctrl: directed checks of debounce latency, cursor stepping and place/invalid strobes
module tb_move_input_ctrl;
    logic       ph1 = 1'b0;
    logic       reset = 1'b0;
    logic       btn_next = 1'b0;
    logic       btn_place = 1'b0;
    logic [8:0] occupied = '0;
    logic       game_over = 1'b0;
    logic [3:0] cursor;
    logic       place_en;
    logic [3:0] place_cell;
    logic       player;
    logic       invalid;
    int checks = 0;
    int errors = 0;
    int pe_n = 0;
    int inv_n = 0;
    int both_n = 0;
    int last_cell = 0;
    int pe0, inv0;
    move_input_ctrl #(.DEBOUNCE_CYCLES(4)) dut (
        .ph1(ph1), .reset(reset), .btn_next(btn_next), .btn_place(btn_place),
        .occupied(occupied), .game_over(game_over), .cursor(cursor),
        .place_en(place_en), .place_cell(place_cell), .player(player), .invalid(invalid)
    );
    always #5 ph1 = ~ph1;
    always @(negedge ph1) begin
        if (place_en) begin
            pe_n++;
            last_cell = int'(place_cell);
        end
        if (invalid) inv_n++;
        if (place_en && invalid) both_n++;
    end
    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask
    task automatic step(input int n);
        repeat (n) @(posedge ph1);
        #1;
    endtask
    task automatic do_reset();
        reset = 1'b0;
        step(2);
        reset = 1'b1;
        step(12);
    endtask
    task automatic press(input logic n, input logic p);
        btn_next = n;
        btn_place = p;
        step(10);
        btn_next = 1'b0;
        btn_place = 1'b0;
        step(12);
    endtask
    initial begin
        step(2);
        check("rst_cursor", 32'(cursor), 0);
        check("rst_player", 32'(player), 0);
        check("rst_place_en", 32'(place_en), 0);
        check("rst_invalid", 32'(invalid), 0);
        check("rst_place_cell", 32'(place_cell), 0);
        reset = 1'b1;
        step(10);
        // 1: exact latency of D+3 edges from the first sampling edge
        btn_next = 1'b1;
        step(7);
        check("t1_before", 32'(cursor), 0);
        step(1);
        check("t1_at_latency", 32'(cursor), 1);
        step(4);
        btn_next = 1'b0;
        step(12);
        check("t1_once", 32'(cursor), 1);
        check("t1_no_place", 32'(pe_n), 0);
        // 2: bouncing input never settles long enough
        for (int i = 0; i < 10; i++) begin
            btn_next = ~btn_next;
            step(2);
        end
        btn_next = 1'b0;
        step(12);
        check("t2_cursor", 32'(cursor), 1);
        check("t2_no_place", 32'(pe_n), 0);
        check("t2_no_invalid", 32'(inv_n), 0);
        // 3: nine presses walk 1..8 then wrap to 0
        do_reset();
        for (int i = 1; i <= 9; i++) begin
            press(1'b1, 1'b0);
            check($sformatf("t3_step%0d", i), 32'(cursor), 32'(i % 9));
        end
        // 4: legal place, then rejected place on the now-occupied cell
        do_reset();
        pe0 = pe_n;
        inv0 = inv_n;
        press(1'b0, 1'b1);
        check("t4_place_en", 32'(pe_n - pe0), 1);
        check("t4_place_cell", 32'(last_cell), 0);
        check("t4_player_o", 32'(player), 1);
        occupied = 9'b000000001;
        press(1'b0, 1'b1);
        check("t4_invalid", 32'(inv_n - inv0), 1);
        check("t4_no_extra_place", 32'(pe_n - pe0), 1);
        check("t4_player_kept", 32'(player), 1);
        // 5: simultaneous NEXT and PLACE
        occupied = '0;
        do_reset();
        repeat (3) press(1'b1, 1'b0);
        check("t5_cursor3", 32'(cursor), 3);
        pe0 = pe_n;
        inv0 = inv_n;
        press(1'b1, 1'b1);
        check("t5_place_en", 32'(pe_n - pe0), 1);
        check("t5_place_cell", 32'(last_cell), 3);
        check("t5_cursor_kept", 32'(cursor), 3);
        check("t5_no_invalid", 32'(inv_n - inv0), 0);
        // 6: held through reset never fires; game_over blocks placing only
        btn_place = 1'b1;
        pe0 = pe_n;
        do_reset();
        step(8);
        check("t6_held_no_fire", 32'(pe_n - pe0), 0);
        btn_place = 1'b0;
        step(12);
        press(1'b0, 1'b1);
        check("t6_repress", 32'(pe_n - pe0), 1);
        check("t6_player", 32'(player), 1);
        game_over = 1'b1;
        inv0 = inv_n;
        press(1'b0, 1'b1);
        check("t6_go_invalid", 32'(inv_n - inv0), 1);
        check("t6_go_no_place", 32'(pe_n - pe0), 1);
        press(1'b1, 1'b0);
        check("t6_go_next", 32'(cursor), 1);
        check("never_both", 32'(both_n), 0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
